// File: rtl/wb_xbar_pkg.sv
// rtl/wb_xbar_pkg.sv - shared index encoding helpers for the crossbar decoder and return path
package wb_xbar_pkg;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value)
      r++;
    return r;
  endfunction

  // Width of a slave index able to encode 0..ns, where ns means "no slave"
  function automatic int idx_width(input int ns);
    return clog2(ns + 1);
  endfunction

  // The unmapped / none-selected index is always one past the last slave
  function automatic int none_idx(input int ns);
    return ns;
  endfunction

endpackage

// File: rtl/wb_return_mux_idx_fifo.sv
// rtl/wb_return_mux_idx_fifo.sv - in-order FIFO of outstanding slave indices
module idx_fifo
  import wb_xbar_pkg::*;
#(
  parameter int IW      = idx_width(8),
  parameter int LGDEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [IW-1:0] wr_idx,
  output logic          full,
  output logic          empty,
  output logic [IW-1:0] head
);

  localparam int DEPTH = 1 << LGDEPTH;

  logic [IW-1:0]      mem [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr;
  logic [LGDEPTH-1:0] rd_ptr;
  logic [LGDEPTH:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (LGDEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; flush discards everything outstanding
  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge i_clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= wr_idx;
  end

endmodule

// File: rtl/wb_return_mux.sv
// rtl/wb_return_mux.sv - merges slave responses back to the master in request order
module wb_return_mux
  import wb_xbar_pkg::*;
#(
  parameter int NS           = 8,
  parameter int DW           = 32,
  parameter int LGMAXBURST   = 4,
  parameter int OPT_TIMEOUT  = 0,
  parameter int OPT_LOWPOWER = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cyc,
  input  logic             i_valid,
  input  logic [NS:0]      i_decode,
  output logic             o_stall,
  input  logic [NS-1:0]    i_sack,
  input  logic [NS-1:0]    i_serr,
  input  logic [NS*DW-1:0] i_sdata,
  output logic             o_ack,
  output logic             o_err,
  output logic [DW-1:0]    o_data,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam int            IW       = idx_width(NS);
  localparam logic [IW-1:0] NONE_IDX = IW'(none_idx(NS));

  logic [IW-1:0] req_idx;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          flush;
  logic          head_none;
  logic          head_ack;
  logic          head_err;
  logic [DW-1:0] head_data;
  logic          head_resp;
  logic          timeout_fire;

  // Lowest set decode bit wins; all-zero decode falls through to the none index
  always_comb begin
    req_idx = NONE_IDX;
    for (int k = NS; k >= 0; k--)
      if (i_decode[k])
        req_idx = IW'(k);
  end

  // Select the response lines of the slave at the head of the FIFO
  always_comb begin
    head_ack  = 1'b0;
    head_err  = 1'b0;
    head_data = '0;
    for (int k = 0; k < NS; k++) begin
      if (head == IW'(k)) begin
        head_ack  = i_sack[k];
        head_err  = i_serr[k];
        head_data = i_sdata[k*DW +: DW];
      end
    end
  end

  assign head_none = (head == NONE_IDX);
  assign head_resp = !empty && (head_none || head_ack || head_err);
  assign push      = i_cyc && i_valid && !full;
  assign pop       = i_cyc && head_resp && !timeout_fire;
  assign flush     = !i_cyc || timeout_fire;
  assign o_stall   = full;
  assign o_busy    = !empty;

  idx_fifo #(
    .IW      (IW),
    .LGDEPTH (LGMAXBURST)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_idx  (req_idx),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  generate
    if (OPT_TIMEOUT > 0) begin : g_timeout
      localparam int TW = (clog2(OPT_TIMEOUT + 1) < 1) ? 1 : clog2(OPT_TIMEOUT + 1);
      logic [TW-1:0] to_cnt;

      // Counts cycles the head has waited; any pop or empty FIFO restarts it
      always_ff @(posedge i_clk) begin
        if (i_reset || !i_cyc || empty || pop || timeout_fire)
          to_cnt <= '0;
        else
          to_cnt <= to_cnt + 1'b1;
      end

      assign timeout_fire = i_cyc && !empty && (to_cnt == TW'(OPT_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_fire = 1'b0;
    end
  endgenerate

  // Registered master response; abort beats timeout, timeout beats a head response
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_data    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      if (OPT_LOWPOWER != 0)
        o_data <= '0;
      if (!i_cyc) begin
        o_ack <= 1'b0;
        o_err <= 1'b0;
      end else if (timeout_fire) begin
        o_err     <= 1'b1;
        o_timeout <= 1'b1;
      end else if (pop) begin
        if (head_none) begin
          o_err <= 1'b1;
        end else begin
          o_ack <= head_ack && !head_err;
          o_err <= head_err;
          if ((OPT_LOWPOWER == 0) || (head_ack && !head_err))
            o_data <= head_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_return_mux.sv
// tb/tb_wb_return_mux.sv - directed self-checking bench for wb_return_mux
module tb_wb_return_mux;

  localparam int NS = 8;
  localparam int DW = 32;

  logic             clk;
  logic             rst;
  logic             cyc;
  logic             valid;
  logic [NS:0]      decode;
  logic [NS-1:0]    sack;
  logic [NS-1:0]    serr;
  logic [NS*DW-1:0] sdata;

  logic          stall0, ack0, err0, to0, busy0;
  logic [DW-1:0] data0;
  logic          stall1, ack1, err1, to1, busy1;
  logic [DW-1:0] data1;

  int tests;
  int fails;

  wb_return_mux #(
    .NS(NS), .DW(DW), .LGMAXBURST(4), .OPT_TIMEOUT(0), .OPT_LOWPOWER(0)
  ) u0 (
    .i_clk(clk), .i_reset(rst), .i_cyc(cyc), .i_valid(valid), .i_decode(decode),
    .o_stall(stall0), .i_sack(sack), .i_serr(serr), .i_sdata(sdata),
    .o_ack(ack0), .o_err(err0), .o_data(data0), .o_timeout(to0), .o_busy(busy0)
  );

  wb_return_mux #(
    .NS(NS), .DW(DW), .LGMAXBURST(4), .OPT_TIMEOUT(8), .OPT_LOWPOWER(1)
  ) u1 (
    .i_clk(clk), .i_reset(rst), .i_cyc(cyc), .i_valid(valid), .i_decode(decode),
    .o_stall(stall1), .i_sack(sack), .i_serr(serr), .i_sdata(sdata),
    .o_ack(ack1), .o_err(err1), .o_data(data1), .o_timeout(to1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k);
    valid     = 1'b1;
    decode    = '0;
    decode[k] = 1'b1;
  endtask

  task automatic resp(input int k, input logic [31:0] d);
    sack            = '0;
    sack[k]         = 1'b1;
    sdata[k*DW +: DW] = d;
  endtask

  initial begin
    int exp_slv [16];
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    cyc    = 1'b0;
    valid  = 1'b0;
    decode = '0;
    sack   = '0;
    serr   = '0;
    sdata  = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_ack", ack0, 0);
    chk("reset_err", err0, 0);
    chk("reset_data", data0, 0);
    chk("reset_timeout", to1, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_stall", stall0, 0);

    // In-order responses from slaves 2, 5, 2
    cyc = 1'b1;
    req(2); step();
    req(5); step();
    req(2); step();
    valid = 1'b0;
    chk("t1_busy", busy0, 1);
    resp(2, 32'hA);
    chk("t1_no_early_ack", ack0, 0);
    step();
    chk("t1_ack_a", ack0, 1);
    chk("t1_data_a", data0, 32'hA);
    resp(5, 32'hB); step();
    chk("t1_ack_b", ack0, 1);
    chk("t1_data_b", data0, 32'hB);
    resp(2, 32'hC); step();
    chk("t1_ack_c", ack0, 1);
    chk("t1_data_c", data0, 32'hC);
    chk("t1_idle", busy0, 0);
    sack = '0; step();
    chk("t1_ack_pulse", ack0, 0);
    chk("t1_data_hold", data0, 32'hC);
    chk("t1_lowpower_zero", data1, 0);

    // Out-of-order response from non-head slave is dropped
    req(1); step();
    req(3); step();
    valid = 1'b0;
    resp(3, 32'h33); step();
    chk("t2_drop_ack", ack0, 0);
    chk("t2_busy", busy0, 1);
    resp(1, 32'h11); step();
    chk("t2_ack1", ack0, 1);
    chk("t2_data1", data0, 32'h11);
    resp(3, 32'h33); step();
    chk("t2_ack3", ack0, 1);
    chk("t2_data3", data0, 32'h33);
    chk("t2_idle", busy0, 0);
    sack = '0;

    // Unmapped request (bit NS) and all-zero decode both error
    req(NS); step();
    valid = 1'b0;
    chk("t3_err_not_yet", err0, 0);
    step();
    chk("t3_err", err0, 1);
    chk("t3_no_ack", ack0, 0);
    step();
    chk("t3_err_pulse", err0, 0);
    chk("t3_idle", busy0, 0);
    valid = 1'b1; decode = '0; step();
    valid = 1'b0; step();
    chk("t3_zero_decode_err", err0, 1);

    // Slave error response: err without ack
    req(6); step();
    valid = 1'b0;
    resp(6, 32'h66); serr[6] = 1'b1; step();
    chk("t3_serr_err", err0, 1);
    chk("t3_serr_ack", ack0, 0);
    sack = '0; serr = '0; step();

    // Fill all 16 slots
    for (int i = 0; i < 16; i++) begin
      req(i % 8);
      step();
    end
    chk("t4_full_stall", stall0, 1);
    chk("t4_full_busy", busy0, 1);
    resp(0, 32'h100);
    req(7);
    chk("t4_stall_with_pop", stall0, 1);
    step();
    chk("t4_pop_ack", ack0, 1);
    chk("t4_stall_drop", stall0, 0);
    sack = '0;
    step();
    chk("t4_refill_stall", stall0, 1);
    valid = 1'b0;
    for (int i = 0; i < 15; i++) exp_slv[i] = (i + 1) % 8;
    exp_slv[15] = 7;
    for (int i = 0; i < 16; i++) begin
      resp(exp_slv[i], 32'h200 + i);
      step();
      chk("t4_drain_ack", ack0, 1);
      chk("t4_drain_data", data0, 32'h200 + i);
    end
    sack = '0;
    chk("t4_drained", busy0, 0);

    // Timeout on the OPT_TIMEOUT=8 instance
    rst = 1'b1; step(); rst = 1'b0;
    req(4); step();
    valid = 1'b0;
    chk("t5_err_e0", err1, 0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t5_no_err_early", err1, 0);
    end
    step();
    chk("t5_err", err1, 1);
    chk("t5_timeout", to1, 1);
    chk("t5_busy", busy1, 0);
    chk("t5_ref_busy", busy0, 1);
    chk("t5_ref_no_timeout", to0, 0);
    step();
    chk("t5_timeout_pulse", to1, 0);
    resp(4, 32'h44); step();
    chk("t5_late_ack", ack1, 0);
    chk("t5_lowpower_data", data1, 0);
    chk("t5_ref_late_ack", ack0, 1);
    sack = '0;

    // Abort with i_cyc low
    req(1); step();
    req(2); step();
    req(3); step();
    valid = 1'b0;
    cyc = 1'b0;
    resp(1, 32'h11);
    step();
    chk("t6_abort_busy", busy0, 0);
    chk("t6_abort_ack", ack0, 0);
    cyc = 1'b1;
    resp(2, 32'h22); step();
    chk("t6_stale_ack", ack0, 0);
    sack = '0;
    req(5); step();
    valid = 1'b0;
    resp(5, 32'h55); step();
    chk("t6_new_ack", ack0, 1);
    chk("t6_new_data", data0, 32'h55);
    chk("t6_idle", busy0, 0);
    sack = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
